// File: rtl/vec_load_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vlb_pkg
// Purpose  : Shared types and helpers for the vector load buffer.
//            - state_t   : fill/hold state of the vector assembler
//            - bsel_w()  : bank-select width for a given bank count
//            - VEC_CNT_W : width of the completed-handoff counter
// Revision : 1.0  initial release
// ============================================================================
package vlb_pkg;

    localparam int VEC_CNT_W = 16;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // At least one select bit even for a single-bank build.
    function automatic int bsel_w(input int nbank);
        return (nbank > 1) ? $clog2(nbank) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_load_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_load_buffer_if
// Purpose  : Bank-write and vector-handoff bus of the vector load buffer.
// Signals  : in_valid/in_ready/in_bank/in_data  - bank write channel
//            out_valid/out_ready/y               - vector handoff channel
//            err                                 - rejected-write pulse
//            vec_cnt                             - completed handoff count
// Modports : master (producer/consumer side), slave (buffer side)
// Revision : 1.0  initial release
// ============================================================================
interface vec_load_buffer_if #(
    parameter int WIDTH = 3,
    parameter int LANES = 2,
    parameter int NBANK = 2
);
    import vlb_pkg::*;

    localparam int BSEL_W = bsel_w(NBANK);

    logic                         in_valid;
    logic                         in_ready;
    logic [BSEL_W-1:0]            in_bank;
    logic [LANES*WIDTH-1:0]       in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [NBANK*LANES*WIDTH-1:0] y;
    logic                         err;
    logic [VEC_CNT_W-1:0]         vec_cnt;

    modport master (
        output in_valid, in_bank, in_data, out_ready,
        input  in_ready, out_valid, y, err, vec_cnt
    );

    modport slave (
        input  in_valid, in_bank, in_data, out_ready,
        output in_ready, out_valid, y, err, vec_cnt
    );

endinterface
`default_nettype wire

// File: rtl/vec_load_buffer_bank.sv
`default_nettype none
// ============================================================================
// Module   : vlb_bank
// Purpose  : One bank register of the vector load buffer.
// Ports    : clk     - rising-edge clock
//            rst     - asynchronous reset, active-high (clears to 0)
//            i_load  - load enable
//            i_data  - bank payload
//            o_q     - registered bank contents
// Revision : 1.0  initial release
// ============================================================================
module vlb_bank #(
    parameter int BANK_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [BANK_W-1:0] i_data,
    output logic [BANK_W-1:0] o_q
);

    logic [BANK_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/vec_load_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vec_load_buffer
// Purpose  : Assembles an NBANK-bank vector from bank writes and hands it
//            downstream over a valid/ready handshake.
//            MODE 0: banks filled in order by an internal pointer.
//            MODE 1: bank chosen by in_bank; out-of-range writes and (unless
//                    VEC_LOAD_BANK_OVERWRITE_EN is defined) writes to an
//                    already-loaded bank are dropped with an err pulse.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous reset, active-high
//            bus  - vec_load_buffer_if.slave (write, handoff, err, vec_cnt)
// Macro    : VEC_LOAD_BANK_OVERWRITE_EN - MODE 1 rewrite of a loaded bank
//            overwrites it silently instead of being rejected.
// Revision : 1.0  initial release
// ============================================================================
module vec_load_buffer
    import vlb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LANES = 2,
    parameter int NBANK = 2,
    parameter int MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    vec_load_buffer_if.slave  bus
);

    localparam int c_B      = LANES * WIDTH;
    localparam int c_BSEL_W = bsel_w(NBANK);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NBANK-1:0]       r_mask;
    logic [NBANK-1:0]       w_mask_base;
    logic [NBANK-1:0]       w_mask_next;
    logic [NBANK-1:0]       w_sel_onehot;
    logic [c_BSEL_W-1:0]    w_sel;
    logic                   w_accept;
    logic                   w_handoff;
    logic                   w_reject;
    logic                   w_we;
    logic                   w_full_next;
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   r_err;
    logic [VEC_CNT_W-1:0]   r_vec_cnt;
    logic [NBANK*c_B-1:0]   w_y;

    assign w_handoff = (r_state == HOLD) && bus.out_ready;
    assign w_accept  = bus.in_valid && w_in_ready;

    // A write that coincides with a handoff starts the next vector, so it
    // is judged and merged against an empty mask.
    assign w_mask_base = w_handoff ? '0 : r_mask;

    always_comb begin
        w_sel_onehot = '0;
        for (int k = 0; k < NBANK; k++) begin
            w_sel_onehot[k] = (w_sel == c_BSEL_W'(k));
        end
    end

    generate
        if (MODE == 0) begin : g_seq
            localparam logic [c_BSEL_W-1:0] c_LAST = c_BSEL_W'(NBANK - 1);
            logic [c_BSEL_W-1:0] r_ptr;
            logic                w_unused_bank;

            assign w_unused_bank = ^bus.in_bank;
            assign w_sel         = r_ptr;
            assign w_reject      = 1'b0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_we) begin
                    r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
                end else if (w_handoff) begin
                    r_ptr <= '0;
                end
            end
        end else begin : g_addr
            logic w_range_bad;

            assign w_sel = bus.in_bank;

            // Only a non-power-of-two bank count leaves unused select codes.
            if ((2 ** c_BSEL_W) != NBANK) begin : g_range
                localparam logic [c_BSEL_W:0] c_NBANK_EXT = (c_BSEL_W + 1)'(NBANK);
                assign w_range_bad = ({1'b0, bus.in_bank} >= c_NBANK_EXT);
            end else begin : g_no_range
                assign w_range_bad = 1'b0;
            end

`ifdef VEC_LOAD_BANK_OVERWRITE_EN
            assign w_reject = w_range_bad;
`else
            assign w_reject = w_range_bad || (|(w_mask_base & w_sel_onehot));
`endif
        end
    endgenerate

    assign w_we        = w_accept && !w_reject;
    assign w_mask_next = w_mask_base | (w_we ? w_sel_onehot : '0);
    assign w_full_next = &w_mask_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_full_next) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // With a single bank, the write riding on the handoff
                // already completes the next vector.
                if (w_handoff) begin
                    w_state_next = w_full_next ? HOLD : FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        if (!rst) begin
            case (r_state)
                FILL:    w_in_ready = 1'b1;
                HOLD: begin
                    w_out_valid = 1'b1;
                    w_in_ready  = bus.out_ready;
                end
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    // ---------------- mask, error pulse, handoff counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask    <= '0;
            r_err     <= 1'b0;
            r_vec_cnt <= '0;
        end else begin
            r_mask <= w_mask_next;
            r_err  <= w_accept && w_reject;
            if (w_handoff) begin
                r_vec_cnt <= r_vec_cnt + VEC_CNT_W'(1);
            end
        end
    end

    // ---------------- bank registers ----------------
    generate
        for (genvar k = 0; k < NBANK; k++) begin : g_bank
            vlb_bank #(
                .BANK_W (c_B)
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_we && w_sel_onehot[k]),
                .i_data (bus.in_data),
                .o_q    (w_y[k*c_B +: c_B])
            );
        end
    endgenerate

    assign bus.y         = w_y;
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.err       = r_err;
    assign bus.vec_cnt   = r_vec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vec_load_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_load_buffer
// Purpose  : Self-checking bench for vec_load_buffer. Two instances:
//            dut_a (MODE 0, NBANK 2) and dut_b (MODE 1, NBANK 3). A
//            behavioural model predicts completed vectors and error pulses
//            into queues; a monitor pops and compares them as the DUTs
//            present handoffs and err pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_vec_load_buffer;
    import vlb_pkg::*;

    localparam int W  = 3;
    localparam int L  = 2;
    localparam int NA = 2;
    localparam int NB = 3;
`ifdef VEC_LOAD_BANK_OVERWRITE_EN
    localparam bit c_OVR = 1'b1;
`else
    localparam bit c_OVR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_load_buffer_if #(.WIDTH(W), .LANES(L), .NBANK(NA)) ifa ();
    vec_load_buffer_if #(.WIDTH(W), .LANES(L), .NBANK(NB)) ifb ();

    vec_load_buffer #(.WIDTH(W), .LANES(L), .NBANK(NA), .MODE(0)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa));
    vec_load_buffer #(.WIDTH(W), .LANES(L), .NBANK(NB), .MODE(1)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb));

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] y;
        int          cnt;
    } vec_t;

    // Model: bank contents, which banks hold data for the vector being
    // assembled, whether a full vector awaits handoff, vectors completed.
    logic [5:0] m_bank [2][3];
    bit         m_ld   [2][3];
    bit         m_hold [2];
    int         m_done [2];
    vec_t       qa[$], qb[$];
    int         ea[$], eb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nloaded(input int d, input int nb);
        int n = 0;
        for (int k = 0; k < nb; k++) n += int'(m_ld[d][k]);
        return n;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_hold[d] = 1'b0;
            m_done[d] = 0;
            for (int k = 0; k < 3; k++) begin
                m_bank[d][k] = '0;
                m_ld[d][k]   = 1'b0;
            end
        end
        qa.delete(); qb.delete(); ea.delete(); eb.delete();
    endtask

    // One clock edge worth of behaviour for one buffer, given its inputs.
    task automatic model_step(input int d, input int nb, input int mode, input bit v,
                              input int bank, input logic [5:0] data, input bit ordy,
                              output bit rdy);
        vec_t e;
        int   tgt;
        bit   ok;
        rdy = !m_hold[d] || ordy;
        if (m_hold[d] && ordy) begin
            m_hold[d] = 1'b0;
            for (int k = 0; k < 3; k++) m_ld[d][k] = 1'b0;
        end
        if (v && rdy) begin
            tgt = (mode == 0) ? nloaded(d, nb) : bank;
            ok  = (tgt < nb);
            if (ok && mode == 1 && m_ld[d][tgt]) ok = c_OVR;
            if (!ok) begin
                if (d == 0) ea.push_back(cyc + 1); else eb.push_back(cyc + 1);
            end else begin
                m_bank[d][tgt] = data;
                m_ld[d][tgt]   = 1'b1;
                if (nloaded(d, nb) == nb) begin
                    m_hold[d] = 1'b1;
                    e.y = '0;
                    for (int k = 0; k < nb; k++) e.y[k*6 +: 6] = m_bank[d][k];
                    e.cnt = m_done[d];
                    m_done[d]++;
                    if (d == 0) qa.push_back(e); else qb.push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input bit va, input int ba, input logic [5:0] da, input bit ra,
                         input bit vb, input int bb, input logic [5:0] db, input bit rb);
        bit rdy_a, rdy_b;
        @(posedge clk); #1;
        ifa.in_valid = va; ifa.in_bank = 1'(ba); ifa.in_data = da; ifa.out_ready = ra;
        ifb.in_valid = vb; ifb.in_bank = 2'(bb); ifb.in_data = db; ifb.out_ready = rb;
        model_step(0, NA, 0, va, ba, da, ra, rdy_a);
        model_step(1, NB, 1, vb, bb, db, rb, rdy_b);
        #1;
        chk("in_ready_a", 32'(ifa.in_ready), 32'(rdy_a));
        chk("in_ready_b", 32'(ifb.in_ready), 32'(rdy_b));
    endtask

    task automatic idle(input bit ra, input bit rb);
        drive(1'b0, 0, 6'h00, ra, 1'b0, 0, 6'h00, rb);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
        model_clear();
        #1;
        chk("rst_in_ready_a", 32'(ifa.in_ready), 0);
        chk("rst_out_valid_a", 32'(ifa.out_valid), 0);
        chk("rst_y_a", 32'(ifa.y), 0);
        chk("rst_vec_cnt_a", 32'(ifa.vec_cnt), 0);
        chk("rst_y_b", 32'(ifb.y), 0);
        chk("rst_err_b", 32'(ifb.err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        vec_t e;
        int   c;
        if (!rst) begin
            if (ifa.out_valid && ifa.out_ready) begin
                if (qa.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL vec_a unexpected handoff actual=%0h required=none", ifa.y);
                end else begin
                    e = qa.pop_front();
                    chk("vec_a_y", 32'(ifa.y), 32'(e.y));
                    chk("vec_a_cnt", 32'(ifa.vec_cnt), 32'(e.cnt));
                end
            end
            if (ifb.out_valid && ifb.out_ready) begin
                if (qb.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL vec_b unexpected handoff actual=%0h required=none", ifb.y);
                end else begin
                    e = qb.pop_front();
                    chk("vec_b_y", 32'(ifb.y), 32'(e.y));
                    chk("vec_b_cnt", 32'(ifb.vec_cnt), 32'(e.cnt));
                end
            end
            if (ifa.err) begin
                if (ea.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL err_a unexpected pulse actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    c = ea.pop_front();
                    chk("err_a_cycle", 32'(cyc), 32'(c));
                end
            end
            if (ifb.err) begin
                if (eb.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL err_b unexpected pulse actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    c = eb.pop_front();
                    chk("err_b_cycle", 32'(cyc), 32'(c));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : drv
        logic [17:0] exp_b;
        ifa.in_valid = 1'b0; ifa.in_bank = '0; ifa.in_data = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_bank = '0; ifb.in_data = '0; ifb.out_ready = 1'b0;
        model_clear();

        // Reset held for two cycles
        repeat (2) begin
            @(negedge clk);
            chk("init_y_a", 32'(ifa.y), 0);
            chk("init_out_valid_a", 32'(ifa.out_valid), 0);
            chk("init_in_ready_a", 32'(ifa.in_ready), 0);
            chk("init_vec_cnt_a", 32'(ifa.vec_cnt), 0);
            chk("init_in_ready_b", 32'(ifb.in_ready), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready_a", 32'(ifa.in_ready), 1);
        chk("release_in_ready_b", 32'(ifb.in_ready), 1);

        // Sequential fill, hold under back-pressure, handoff with write
        drive(1, 0, 6'h05, 0, 0, 0, 6'h00, 0);
        drive(1, 0, 6'h02, 0, 0, 0, 6'h00, 0);
        idle(0, 0);
        @(negedge clk);
        chk("seq_out_valid", 32'(ifa.out_valid), 1);
        chk("seq_y", 32'(ifa.y), 32'h085);
        repeat (5) begin
            idle(0, 0);
            @(negedge clk);
            chk("hold_y", 32'(ifa.y), 32'h085);
            chk("hold_in_ready", 32'(ifa.in_ready), 0);
        end
        drive(1, 0, 6'h3F, 1, 0, 0, 6'h00, 0);
        idle(0, 0);
        @(negedge clk);
        chk("handoff_out_valid", 32'(ifa.out_valid), 0);
        chk("handoff_vec_cnt", 32'(ifa.vec_cnt), 1);
        chk("handoff_y", 32'(ifa.y), 32'h0BF);
        drive(1, 0, 6'h2A, 0, 0, 0, 6'h00, 0);
        idle(0, 0);
        @(negedge clk);
        chk("refill_y", 32'(ifa.y), 32'hABF);
        chk("refill_out_valid", 32'(ifa.out_valid), 1);
        idle(1, 0);
        idle(0, 0);

        // Addressed fill with a duplicate bank write, then out-of-range bank
        drive(0, 0, 6'h00, 0, 1, 1, 6'h01, 0);
        drive(0, 0, 6'h00, 0, 1, 1, 6'h07, 0);
        drive(0, 0, 6'h00, 0, 1, 0, 6'h00, 0);
        drive(0, 0, 6'h00, 0, 1, 2, 6'h05, 0);
        idle(0, 0);
        @(negedge clk);
        exp_b = {6'h05, (c_OVR ? 6'h07 : 6'h01), 6'h00};
        chk("addr_y", 32'(ifb.y), 32'(exp_b));
        chk("addr_bank1", 32'(ifb.y[11:6]), c_OVR ? 32'h07 : 32'h01);
        chk("addr_out_valid", 32'(ifb.out_valid), 1);
        idle(0, 1);
        drive(0, 0, 6'h00, 0, 1, 3, 6'h15, 0);
        idle(0, 0);
        @(negedge clk);
        chk("range_err", 32'(ifb.err), 1);
        chk("range_y_unchanged", 32'(ifb.y), 32'(exp_b));
        chk("range_out_valid", 32'(ifb.out_valid), 0);

        // Reset mid-fill discards partial vector
        drive(1, 0, 6'h07, 0, 0, 0, 6'h00, 0);
        do_reset();
        drive(1, 0, 6'h11, 0, 0, 0, 6'h00, 0);
        drive(1, 0, 6'h22, 0, 0, 0, 6'h00, 0);
        idle(0, 0);
        @(negedge clk);
        chk("post_rst_y", 32'(ifa.y), 32'h891);
        chk("post_rst_out_valid", 32'(ifa.out_valid), 1);
        idle(1, 0);

        // Randomised traffic on both buffers
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)), 6'($urandom),
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 6'($urandom),
                      $urandom_range(0, 2) != 0);
            end
        end

        // Drain
        repeat (8) idle(1, 1);
        @(negedge clk);
        chk("drain_vec_a", 32'(qa.size()), 0);
        chk("drain_vec_b", 32'(qb.size()), 0);
        chk("drain_err_a", 32'(ea.size()), 0);
        chk("drain_err_b", 32'(eb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
